// File: rtl/clk_gate_pkg.sv
// Shared definitions for the peripheral clock-request controller.
//   chan_state_e     : per-channel request FSM state
//   MIN_*            : lowest legal parameter values, checked at elaboration
//   cnt_width()      : width of the shared wake/idle down-counter
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CH_OFF  = 2'd0,
        CH_WAKE = 2'd1,
        CH_ON   = 2'd2,
        CH_IDLE = 2'd3
    } chan_state_e;

    localparam int MIN_N           = 1;
    localparam int MIN_WAKE_LAT    = 1;
    localparam int MIN_IDLE_CYCLES = 1;

    // One counter serves both WAKE and IDLE, so size it for the larger load.
    function automatic int cnt_width(input int wake_lat, input int idle_cycles);
        int m;
        m = (wake_lat > idle_cycles) ? wake_lat : idle_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clk_req_chan.sv
// Single-channel clock request FSM (OFF -> WAKE -> ON <-> IDLE -> OFF).
//   clk_i   : source clock
//   rst_ni  : async active-low reset
//   en_i    : software enable, forces OFF when low (beats wake_i)
//   wake_i  : peripheral activity level
//   req_o   : FSM wants the clock (WAKE/ON/IDLE), straight from the state flop
//   ack_o   : clock guaranteed running (ON/IDLE), straight from the state flop
module clk_req_chan
    import clk_gate_pkg::*;
#(
    parameter int WAKE_LAT    = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic wake_i,
    output logic req_o,
    output logic ack_o
);

    localparam int CW = cnt_width(WAKE_LAT, IDLE_CYCLES);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CH_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Loading N-1 and leaving on zero makes the state last exactly N edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            state_d = CH_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CH_OFF: begin
                    if (wake_i) begin
                        state_d = CH_WAKE;
                        cnt_d   = CW'(WAKE_LAT - 1);
                    end
                end
                CH_WAKE: begin
                    // wake_i is deliberately ignored until the clock is up.
                    if (cnt_q == '0) begin
                        state_d = CH_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                CH_ON: begin
                    if (!wake_i) begin
                        state_d = CH_IDLE;
                        cnt_d   = CW'(IDLE_CYCLES - 1);
                    end
                end
                CH_IDLE: begin
                    if (wake_i) begin
                        state_d = CH_ON;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = CH_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = CH_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ack is a subset of req, so ack can never outlive req.
    assign req_o = (state_q != CH_OFF);
    assign ack_o = (state_q == CH_ON) || (state_q == CH_IDLE);

endmodule

// File: rtl/clk_req_ctrl.sv
// Peripheral clock request controller: N independent request FSMs plus a
// registered force override and a live count of requesting channels.
//   clk_in     : free-running source clock
//   rst_n      : async active-low reset
//   wake_req   : per-peripheral activity [N]
//   en         : per-channel software enable [N]
//   force_on   : request every clock (test/bring-up)
//   clk_req    : request to downstream gater [N]
//   clk_ack    : clock guaranteed running [N]
//   active_cnt : number of channels whose FSM requests clock (force excluded)
module clk_req_ctrl
    import clk_gate_pkg::*;
#(
    parameter int N           = 4,
    parameter int WAKE_LAT    = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [N-1:0]           wake_req,
    input  logic [N-1:0]           en,
    input  logic                   force_on,
    output logic [N-1:0]           clk_req,
    output logic [N-1:0]           clk_ack,
    output logic [$clog2(N+1)-1:0] active_cnt
);

    localparam int ACW = $clog2(N + 1);

    if (N < MIN_N || WAKE_LAT < MIN_WAKE_LAT || IDLE_CYCLES < MIN_IDLE_CYCLES) begin : g_bad_param
        $error("clk_req_ctrl: N, WAKE_LAT and IDLE_CYCLES must all be >= 1");
    end

    logic [N-1:0]   chan_req;
    logic [N-1:0]   chan_ack;
    logic           force_q;
    logic [ACW-1:0] cnt_sum;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            force_q <= 1'b0;
        end else begin
            force_q <= force_on;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_chan
        clk_req_chan #(
            .WAKE_LAT   (WAKE_LAT),
            .IDLE_CYCLES(IDLE_CYCLES)
        ) u_chan (
            .clk_i (clk_in),
            .rst_ni(rst_n),
            .en_i  (en[i]),
            .wake_i(wake_req[i]),
            .req_o (chan_req[i]),
            .ack_o (chan_ack[i])
        );
    end

    // ACW is sized for N, so the sum cannot overflow.
    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < N; i++) begin
            cnt_sum = cnt_sum + ACW'(chan_req[i]);
        end
    end

    // Force only widens the request; acks still follow the real FSM handshake.
    assign clk_req    = chan_req | {N{force_q}};
    assign clk_ack    = chan_ack;
    assign active_cnt = cnt_sum;

endmodule

// File: tb/tb_clk_req_ctrl.sv
module tb_clk_req_ctrl;

    localparam int N           = 4;
    localparam int WAKE_LAT    = 2;
    localparam int IDLE_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] wake_req = '0;
    logic [3:0] en = '0;
    logic       force_on = 1'b0;
    logic [3:0] clk_req;
    logic [3:0] clk_ack;
    logic [2:0] active_cnt;

    int checks = 0;
    int failures = 0;

    clk_req_ctrl #(.N(N), .WAKE_LAT(WAKE_LAT), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .wake_req  (wake_req),
        .en        (en),
        .force_on  (force_on),
        .clk_req   (clk_req),
        .clk_ack   (clk_ack),
        .active_cnt(active_cnt)
    );

    always #5 clk = ~clk;

    // Reference model in terms of event times: when a channel's request rose,
    // and when its current unbroken run of low activity began.
    bit m_req[N];
    int m_rise[N];
    int m_low[N];
    bit m_force;
    int t = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b0; m_rise[i] = 0; m_low[i] = -1;
        end
        m_force = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] e, input logic [3:0] w, input logic f);
        bit acked_before;
        t++;
        for (int i = 0; i < N; i++) begin
            acked_before = m_req[i] && ((t - 1 - m_rise[i]) >= WAKE_LAT);
            if (!e[i]) begin
                m_req[i] = 1'b0;
            end else if (!m_req[i]) begin
                if (w[i]) begin
                    m_req[i] = 1'b1; m_rise[i] = t; m_low[i] = -1;
                end
            end else if (acked_before) begin
                if (w[i])                          m_low[i] = -1;
                else if (m_low[i] < 0)             m_low[i] = t;
                else if (t - m_low[i] == IDLE_CYCLES) m_req[i] = 1'b0;
            end
        end
        m_force = f;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] er, ea;
        logic [2:0] ec;
        er = '0; ea = '0; ec = '0;
        for (int i = 0; i < N; i++) begin
            if (m_req[i]) begin
                er[i] = 1'b1;
                ec = ec + 3'd1;
                if (t - m_rise[i] >= WAKE_LAT) ea[i] = 1'b1;
            end
        end
        if (m_force) er = '1;
        check({tag, "_req"}, 32'(clk_req), 32'(er));
        check({tag, "_ack"}, 32'(clk_ack), 32'(ea));
        check({tag, "_cnt"}, 32'(active_cnt), 32'(ec));
    endtask

    // One active edge; model sees the same inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        model_edge(en, wake_req, force_on);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0; wake_req = '0; force_on = 1'b0;
        model_reset();
        #1;
        check("reset_req", 32'(clk_req), 32'h0);
        check("reset_ack", 32'(clk_ack), 32'h0);
        check("reset_cnt", 32'(active_cnt), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] wake;
        logic       frc;
        logic [3:0] exp_req;
        logic [3:0] exp_ack;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit drop_seen;

        vecs[0] = '{4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0};
        vecs[1] = '{4'hF, 4'h3, 1'b0, 4'h3, 4'h0, 3'd2}; // ch0,ch1 -> WAKE
        vecs[2] = '{4'hD, 4'h3, 1'b0, 4'h1, 4'h0, 3'd1}; // en[1] dropped mid-WAKE
        vecs[3] = '{4'hF, 4'h1, 1'b0, 4'h1, 4'h1, 3'd1}; // ch0 ack after 2 edges
        vecs[4] = '{4'hF, 4'h0, 1'b1, 4'hF, 4'h1, 3'd1}; // force, ch0 -> IDLE
        vecs[5] = '{4'hF, 4'h0, 1'b0, 4'h1, 4'h1, 3'd1};
        vecs[6] = '{4'hF, 4'hF, 1'b0, 4'hF, 4'h1, 3'd4}; // ch0 IDLE->ON, rest wake
        vecs[7] = '{4'hE, 4'hF, 1'b0, 4'hE, 4'h0, 3'd3}; // en[0] off from ON
        vecs[8] = '{4'hE, 4'h0, 1'b0, 4'hE, 4'hE, 3'd3}; // ch1..3 acked

        #1;
        do_reset();

        // Table vectors, one edge each.
        for (int v = 0; v < 9; v++) begin
            en = vecs[v].en; wake_req = vecs[v].wake; force_on = vecs[v].frc;
            step();
            check($sformatf("vec%0d_req", v), 32'(clk_req), 32'(vecs[v].exp_req));
            check($sformatf("vec%0d_ack", v), 32'(clk_ack), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d_cnt", v), 32'(active_cnt), 32'(vecs[v].exp_cnt));
        end

        // Wake latency and idle hysteresis on channel 0.
        do_reset();
        en = 4'hF;
        repeat (3) step();
        wake_req = 4'h1;
        step();
        check("wake_req_rise", 32'(clk_req[0]), 32'h1);
        check("wake_ack_low",  32'(clk_ack[0]), 32'h0);
        check("wake_cnt",      32'(active_cnt), 32'h1);
        step();
        check("wake_ack_lat1", 32'(clk_ack[0]), 32'h0);
        step();
        check("wake_ack_lat2", 32'(clk_ack[0]), 32'h1);
        repeat (3) step();
        wake_req = 4'h0;
        step();
        drop_seen = 1'b0;
        for (int k = 1; k < IDLE_CYCLES; k++) begin
            step();
            if (clk_req[0] !== 1'b1 || clk_ack[0] !== 1'b1) drop_seen = 1'b1;
        end
        check("idle_early_drop", 32'(drop_seen), 32'h0);
        step();
        check("idle_drop_req", 32'(clk_req[0]), 32'h0);
        check("idle_drop_ack", 32'(clk_ack[0]), 32'h0);
        check("idle_drop_cnt", 32'(active_cnt), 32'h0);

        // Re-request on the fourth idle edge keeps the clock.
        wake_req = 4'h1;
        repeat (4) step();
        wake_req = 4'h0;
        repeat (4) step();
        wake_req = 4'h1;
        drop_seen = 1'b0;
        repeat (12) begin
            step();
            if (clk_req[0] !== 1'b1 || clk_ack[0] !== 1'b1) drop_seen = 1'b1;
        end
        check("rereq_no_drop", 32'(drop_seen), 32'h0);

        // Force override leaves FSMs and acks alone.
        do_reset();
        en = 4'hF; force_on = 1'b1;
        step(); step();
        check("force_req", 32'(clk_req), 32'hF);
        check("force_ack", 32'(clk_ack), 32'h0);
        check("force_cnt", 32'(active_cnt), 32'h0);
        force_on = 1'b0;
        step();
        check("force_off_req", 32'(clk_req), 32'h0);

        // All channels at once, then async reset in the middle of IDLE.
        en = 4'hF; wake_req = 4'hF;
        step();
        check("all_cnt", 32'(active_cnt), 32'h4);
        check("all_ack0", 32'(clk_ack), 32'h0);
        step(); step();
        check("all_ack", 32'(clk_ack), 32'hF);
        wake_req = 4'h0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_req", 32'(clk_req), 32'h0);
        check("midreset_ack", 32'(clk_ack), 32'h0);
        check("midreset_cnt", 32'(active_cnt), 32'h0);
        #1 rst_n = 1'b1;
        step();
        check_model("post_reset");

        // Randomized run against the event-time model.
        do_reset();
        en = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (wake_req[i]) begin
                    if ($urandom_range(0, 7) == 0) wake_req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 11) == 0) wake_req[i] = 1'b1;
                end
                en[i] = ($urandom_range(0, 39) != 0);
            end
            if ($urandom_range(0, 29) == 0) force_on = ~force_on;
            step();
            check_model("rand");
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_model("rand_reset");
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_req_ctrl.md
CLK_REQ_CTRL -- requirements
Module: clk_req_ctrl

Interface
REQ-001 Parameter N, default 4: number of peripheral channels (N >= 1), matches the N of the downstream clock gater.
REQ-002 Parameter WAKE_LAT, default 2: cycles from clk_req rise to clk_ack rise (>= 1), covering gater latch plus settling.
REQ-003 Parameter IDLE_CYCLES, default 8: hysteresis cycles of inactivity before clk_req drops (>= 1).
REQ-004 clk_in  input  1  free-running source clock; all state on posedge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 wake_req  input  N  per-peripheral activity/request, level-sensitive, synchronous to clk_in.
REQ-007 en  input  N  per-channel software enable; 0 forces the channel off.
REQ-008 force_on  input  1  test/bring-up override; all clocks requested.
REQ-009 clk_req  output  N  clock request to gater, registered.
REQ-010 clk_ack  output  N  clock guaranteed running to peripheral, registered.
REQ-011 active_cnt  output  $clog2(N+1)  number of channels whose FSM currently requests clock.

Function
REQ-012 Each channel SHALL run an independent FSM with states OFF, WAKE, ON, IDLE.
REQ-013 OFF: clk_req=0, clk_ack=0; en[i]&wake_req[i] sampled high -> WAKE after that edge, clk_req=1, wake counter loaded WAKE_LAT-1.
REQ-014 WAKE: clk_req=1, clk_ack=0; counter==0 -> ON (clk_ack=1 after that edge), else decrement; wake_req ignored in WAKE.
REQ-015 Latency: clk_ack SHALL rise exactly WAKE_LAT edges after clk_req rises.
REQ-016 ON: clk_req=1, clk_ack=1; wake_req sampled low -> IDLE, idle counter loaded IDLE_CYCLES-1.
REQ-017 IDLE: clk_req=1, clk_ack=1; wake_req high -> ON (counter discarded); else counter==0 -> OFF with clk_req=0, clk_ack=0; else decrement.
REQ-018 clk_req SHALL fall exactly IDLE_CYCLES edges after the first edge sampling wake_req low in ON, absent re-request.
REQ-019 en[i]=0 sampled at an edge SHALL move channel i to OFF from any state, both outputs 0 after that edge; en has priority over wake_req.
REQ-020 clk_ack SHALL fall no later than clk_req (same edge); clk_ack=1 with clk_req=0 never occurs.
REQ-021 force_on SHALL be registered once; while the register is 1, every clk_req bit is 1; FSMs and clk_ack continue unaffected.
REQ-022 active_cnt SHALL equal popcount of FSM request bits (WAKE/ON/IDLE), excluding force_on, combinational from registers; no overflow at N.
REQ-023 Counter widths SHALL be $clog2(max(WAKE_LAT,IDLE_CYCLES)+1); no wrap-around occurs.

Reset
REQ-024 rst_n low SHALL immediately set all states OFF, counters 0, force register 0, clk_req=0, clk_ack=0, active_cnt=0.
REQ-025 Reset asserted mid-WAKE or mid-IDLE SHALL abort without further edges; after release, channels start from OFF.

Structure
REQ-026 Package clk_gate_pkg SHALL hold the channel state enum (OFF, WAKE, ON, IDLE) and parameter-legality constants.
REQ-027 Per-channel FSM SHALL be sub-module clk_req_chan instantiated N times by generate; top holds force register and popcount.
REQ-028 Parameter legality SHALL be checked at elaboration (N, WAKE_LAT, IDLE_CYCLES >= 1).

Verification
REQ-029 N=4, WAKE_LAT=2: en=4'hF, wake_req[0] high at edge 10 -> clk_req[0]=1 after edge 10, clk_ack[0]=1 after edge 12, active_cnt=1.
REQ-030 IDLE_CYCLES=8: ch0 ON, wake_req[0] low from edge 20 -> clk_req[0], clk_ack[0] fall after edge 28; re-request at edge 24 -> stays high, no drop.
REQ-031 en[1] cleared at edge 15 while ch1 in WAKE -> clk_req[1]=0, clk_ack[1]=0 after edge 15, clk_ack[1] never pulses.
REQ-032 force_on=1 with wake_req=0 -> clk_req=4'hF after two edges, clk_ack=4'h0, active_cnt=0.
REQ-033 All four channels requested at once -> active_cnt=4 after one edge, clk_ack=4'hF two edges later; rst_n pulsed low mid-IDLE -> all outputs 0 immediately.
